// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, arbitrates the single memory port between fetch and
// data access, and gates the decoder's write requests and the pc update.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        dec_rf_we,
  input  logic        dec_dram_we,
  input  logic        mem_rdy,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        err,
  output logic [31:0] inst_retired
);

  localparam logic [6:0]       OpLoad     = 7'b0000011;
  localparam logic [6:0]       OpStore    = 7'b0100011;
  localparam logic [6:0]       OpBranch   = 7'b1100011;
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [31:0]      retired_q;

  logic req_raw, sel_raw, we_raw, ir_raw, pc_raw, rf_raw;
  logic timeout;

  // Fault only when the wait budget is used up and memory still is not ready.
  assign timeout = (cnt_q == TimeoutCnt) && !mem_rdy;

  // Next-state and ungated strobe decode from the current state and inputs.
  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    sel_raw = 1'b0;
    we_raw  = 1'b0;
    ir_raw  = 1'b0;
    pc_raw  = 1'b0;
    rf_raw  = 1'b0;
    unique case (state_q)
      StFetch: begin
        req_raw = 1'b1;
        if (mem_rdy) begin
          ir_raw  = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (opcode == OpLoad || opcode == OpStore) begin
          state_d = StMem;
        end else if (opcode == OpBranch) begin
          pc_raw  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        req_raw = 1'b1;
        sel_raw = 1'b1;
        // Held through the wait; memory commits the write on the rdy cycle.
        we_raw  = dec_dram_we;
        if (mem_rdy) begin
          if (opcode == OpStore) begin
            pc_raw  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StWb: begin
        rf_raw  = dec_rf_we;
        pc_raw  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Strobes drop as soon as reset asserts, without waiting for a clock.
  assign mem_req = req_raw & rst_n;
  assign mem_sel = sel_raw;
  assign mem_we  = we_raw & rst_n;
  assign ir_we   = ir_raw & rst_n;
  assign pc_we   = pc_raw & rst_n;
  assign rf_we   = rf_raw & rst_n;

  assign state        = state_q;
  assign err          = err_q;
  assign inst_retired = retired_q;

  // State, wait counter, sticky fault and retirement counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == StFetch || state_q == StMem) && !mem_rdy) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_d == StHalt) begin
        err_q <= 1'b1;
      end
      if (pc_raw) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle traces are
// built from the stage rules and compared cycle by cycle against the DUT.
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ADD = 7'b0110011;

  logic        clk, rst_n;
  logic [6:0]  opcode;
  logic        dec_rf_we, dec_dram_we, mem_rdy;
  logic        mem_req, mem_sel, mem_we, ir_we, pc_we, rf_we;
  logic [2:0]  state;
  logic        err;
  logic [31:0] inst_retired;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .dec_rf_we(dec_rf_we),
    .dec_dram_we(dec_dram_we), .mem_rdy(mem_rdy), .mem_req(mem_req),
    .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .state(state), .err(err), .inst_retired(inst_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st; logic req; logic sel; logic we; logic ir; logic pc; logic rf;
  } obs_t;
  typedef struct packed { logic [6:0] op; logic rfw; logic dww; logic rdy; } stim_t;

  obs_t  exp_q[$];
  obs_t  got_q[$];
  stim_t stim_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] ret_model;
  logic        err_model;

  // Append one expected cycle plus the stimulus to apply during it.
  function automatic void add_cycle(input logic [2:0] st, input logic req, input logic sel,
                                    input logic we, input logic ir, input logic pc,
                                    input logic rf, input logic [6:0] op, input logic rfw,
                                    input logic dww, input logic rdy);
    obs_t e;
    stim_t s;
    e.st = st; e.req = req; e.sel = sel; e.we = we; e.ir = ir; e.pc = pc; e.rf = rf;
    s.op = op; s.rfw = rfw; s.dww = dww; s.rdy = rdy;
    exp_q.push_back(e);
    stim_q.push_back(s);
    if (pc) ret_model = ret_model + 32'd1;
  endfunction

  // Memory access lasting wait_n not-ready cycles; returns 1 when it times out.
  function automatic bit mem_phase(input logic [2:0] st, input logic sel, input logic we,
                                   input int wait_n, input logic [6:0] op, input logic rfw,
                                   input logic dww, input logic ir_done, input logic pc_done);
    if (wait_n > TO) begin
      for (int i = 0; i <= TO; i++) add_cycle(st, 1, sel, we, 0, 0, 0, op, rfw, dww, 0);
      for (int i = 0; i < 3; i++)
        add_cycle(3'd5, 0, 0, 0, 0, 0, 0, op, rfw, dww, 1'($urandom));
      err_model = 1'b1;
      return 1'b1;
    end
    for (int i = 0; i < wait_n; i++) add_cycle(st, 1, sel, we, 0, 0, 0, op, rfw, dww, 0);
    add_cycle(st, 1, sel, we, ir_done, pc_done, 0, op, rfw, dww, 1);
    return 1'b0;
  endfunction

  // Whole-instruction trace from the stage rules.
  function automatic void model_instr(input logic [6:0] op, input logic rfw, input logic dww,
                                      input int fw, input int dw);
    bit is_ld = (op == LD);
    bit is_st = (op == ST);
    if (mem_phase(3'd0, 0, 0, fw, op, rfw, dww, 1, 0)) return;
    add_cycle(3'd1, 0, 0, 0, 0, 0, 0, op, rfw, dww, 1'($urandom));
    if (op == BR) begin
      add_cycle(3'd2, 0, 0, 0, 0, 1, 0, op, rfw, dww, 1'($urandom));
      return;
    end
    add_cycle(3'd2, 0, 0, 0, 0, 0, 0, op, rfw, dww, 1'($urandom));
    if (is_ld || is_st) begin
      if (mem_phase(3'd3, 1, dww, dw, op, rfw, dww, 0, is_st)) return;
      if (is_st) return;
    end
    add_cycle(3'd4, 0, 0, 0, 0, 1, rfw, op, rfw, dww, 1'($urandom));
  endfunction

  // Drive queued stimulus and record outputs mid-cycle; mem_sel only matters
  // while the port is requested.
  task automatic run_trace();
    obs_t g;
    got_q.delete();
    foreach (stim_q[i]) begin
      opcode = stim_q[i].op; dec_rf_we = stim_q[i].rfw;
      dec_dram_we = stim_q[i].dww; mem_rdy = stim_q[i].rdy;
      @(negedge clk);
      g.st = state; g.req = mem_req; g.we = mem_we; g.ir = ir_we; g.pc = pc_we; g.rf = rf_we;
      g.sel = (state == 3'd0 || state == 3'd3) ? mem_sel : 1'b0;
      got_q.push_back(g);
      @(posedge clk);
      #1;
    end
    stim_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; mem_rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ret_model = '0; err_model = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_rdy = 1'b1; opcode = ADD; dec_rf_we = 1'b1; dec_dram_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++;
    if ({mem_req, mem_we, ir_we, pc_we, rf_we} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%05b exp=00000", {mem_req, mem_we, ir_we, pc_we, rf_we});
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    total++;
    if (inst_retired !== 32'd0) begin
      bad++; $display("FAIL reset_retired got=%0d exp=0", inst_retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ret_model = '0; err_model = 1'b0;
  endtask

  task automatic test_single(input string name, input logic [6:0] op, input logic rfw,
                             input logic dww, input int fw, input int dw);
    apply_reset();
    model_instr(op, rfw, dww, fw, dw);
    run_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cyc%0d got=%03h exp=%03h (st,req,sel,we,ir,pc,rf)", name, i,
                 got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    total++;
    if (inst_retired !== ret_model) begin
      bad++; $display("FAIL %s_retired got=%0d exp=%0d", name, inst_retired, ret_model);
    end
    total++;
    if (err !== err_model) begin
      bad++; $display("FAIL %s_err got=%0b exp=%0b", name, err, err_model);
    end
  endtask

  task automatic test_timeout();
    test_single("fetch_timeout", ADD, 1, 0, TO + 1, 0);
    test_single("fetch_rdy_at_limit", ADD, 1, 0, TO, 0);
    test_single("mem_timeout", LD, 1, 0, 0, TO + 1);
    test_single("mem_rdy_at_limit", ST, 0, 1, 1, TO);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    test_single("pre_store", ADD, 1, 0, 0, 0);
    opcode = ST; dec_dram_we = 1'b1; dec_rf_we = 1'b0; mem_rdy = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if ({state, mem_we} !== {3'd3, 1'b1}) begin
      bad++; $display("FAIL mid_mem_wait got st=%0d we=%0b exp st=3 we=1", state, mem_we);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({state, mem_req, mem_we, ir_we, pc_we, rf_we} !== 8'b0) begin
      bad++; $display("FAIL mid_reset_async got st=%0d strobes=%05b exp 0/00000", state,
                      {mem_req, mem_we, ir_we, pc_we, rf_we});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({state, err, inst_retired, mem_req} !== {3'd0, 1'b0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL mid_reset_release got st=%0d err=%0b ret=%0d req=%0b exp 0/0/0/1",
                      state, err, inst_retired, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [8];
    ops[0] = LD; ops[1] = ST; ops[2] = BR; ops[3] = ADD;
    ops[4] = 7'b0010011; ops[5] = 7'b1101111; ops[6] = 7'b0110111; ops[7] = 7'b0;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 7)];
      if (op == 7'b0) op = 7'($urandom_range(0, 127));
      model_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, TO), $urandom_range(0, TO));
    end
    run_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%03h exp=%03h (st,req,sel,we,ir,pc,rf)", i,
                 got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    total++;
    if (inst_retired !== ret_model) begin
      bad++; $display("FAIL b2b_retired got=%0d exp=%0d", inst_retired, ret_model);
    end
  endtask

  initial begin
    opcode = ADD; dec_rf_we = 1'b0; dec_dram_we = 1'b0; mem_rdy = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single("add", ADD, 1, 0, 0, 0);
    test_single("lw", LD, 1, 0, 0, 3);
    test_single("sw", ST, 1, 1, 0, 2);
    test_single("beq", BR, 1, 1, 2, 0);
    test_single("jal_wait", 7'b1101111, 0, 1, 3, 0);
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
